// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 8-bit accumulator CPU.
// Accepts a framed byte stream (length, instruction bytes, checksum) over a
// valid/ready handshake, writes the instruction bytes into program memory,
// and holds the CPU in reset until a frame has loaded with a good checksum.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] byte_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              restart_i,
    output logic              pm_we_o,
    output logic [ADDR_W-1:0] pm_addr_o,
    output logic [DATA_W-1:0] pm_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    // Number of program memory locations; the largest legal frame length.
    localparam int DEPTH = 1 << ADDR_W;

    // Increment constant sized to the byte counter.
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            state_q,   state_d;
    logic [ADDR_W:0]   len_q,     len_d;
    logic [ADDR_W:0]   cnt_q,     cnt_d;
    logic [DATA_W-1:0] sum_q,     sum_d;
    logic              pm_we_q,   pm_we_d;
    logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
    logic [DATA_W-1:0] pm_data_q, pm_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic accept;
    logic len_ok;

    // The loader takes bytes whenever a frame is in progress; it is closed
    // while a result (DONE or ERROR) is being held.
    assign ready_o = (state_q == ST_LEN) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign accept  = valid_i && ready_o;

    // A length byte is legal only if it fits the program memory and is non-zero.
    assign len_ok  = (byte_i != '0) && (32'(byte_i) <= DEPTH);

    // Next-state and registered-output logic for the whole frame sequence.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        pm_we_d   = 1'b0;
        pm_addr_d = pm_addr_q;
        pm_data_d = pm_data_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        unique case (state_q)
            ST_LEN: begin
                if (accept) begin
                    if (len_ok) begin
                        len_d   = byte_i[ADDR_W:0];
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    pm_we_d   = 1'b1;
                    pm_addr_d = cnt_q[ADDR_W-1:0];
                    pm_data_d = byte_i;
                    sum_d     = sum_q + byte_i;
                    cnt_d     = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == len_q) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (accept) begin
                    if (byte_i == sum_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end
            end

            ST_DONE, ST_ERROR: begin
                if (restart_i) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_LEN;
                end
            end

            default: begin
                cpu_rst_d = 1'b1;
                state_d   = ST_LEN;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and drops a pending write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_LEN;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            pm_we_q   <= 1'b0;
            pm_addr_q <= '0;
            pm_data_q <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            pm_we_q   <= pm_we_d;
            pm_addr_q <= pm_addr_d;
            pm_data_q <= pm_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign pm_we_o   = pm_we_q;
    assign pm_addr_o = pm_addr_q;
    assign pm_data_o = pm_data_q;
    assign cpu_rst_o = cpu_rst_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign words_o   = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames with an expected-write queue
// checked by an independent program-memory write monitor.
module tb_prog_loader;

    logic       clk_i;
    logic       reset_i;
    logic [7:0] byte_i;
    logic       valid_i;
    logic       ready_o;
    logic       restart_i;
    logic       pm_we_o;
    logic [4:0] pm_addr_o;
    logic [7:0] pm_data_o;
    logic       cpu_rst_o;
    logic       done_o;
    logic       err_o;
    logic [5:0] words_o;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t expQ[$];
    int  testsRun = 0;
    int  testsFailed = 0;

    prog_loader #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .byte_i    (byte_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .restart_i (restart_i),
        .pm_we_o   (pm_we_o),
        .pm_addr_o (pm_addr_o),
        .pm_data_o (pm_data_o),
        .cpu_rst_o (cpu_rst_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .words_o   (words_o)
    );

    // 10 time-unit clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Write monitor: every program-memory write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_i);
            if (pm_we_o) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL unexpected_write addr=%0h data=%0h, no write expected", pm_addr_o, pm_data_o);
                end else begin
                    e = expQ.pop_front();
                    if (pm_addr_o !== e.addr || pm_data_o !== e.data) begin
                        testsFailed++;
                        $display("[TB] FAIL write got addr=%0h data=%0h, expected addr=%0h data=%0h",
                                 pm_addr_o, pm_data_o, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Offer one byte starting at a negedge; return at the negedge after it is taken.
    task automatic sendByte(input logic [7:0] b);
        int waitCnt;
        waitCnt = 0;
        byte_i  = b;
        valid_i = 1'b1;
        while (!ready_o && waitCnt < 50) begin
            @(negedge clk_i);
            waitCnt++;
        end
        if (!ready_o) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL handshake_timeout ready_o=%0b expected 1", ready_o);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Send a whole frame, expecting writes for the data bytes when the length is legal.
    task automatic applyStimulus(input logic [7:0] len, input logic [7:0] data[$],
                                 input logic [7:0] cksum, input int maxGap);
        int gap;
        sendByte(len);
        if (len == 8'h00 || len > 8'd32) return;
        for (int i = 0; i < data.size(); i++) begin
            expQ.push_back('{addr: 5'(i), data: data[i]});
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            repeat (gap) @(negedge clk_i);
            sendByte(data[i]);
        end
        gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        repeat (gap) @(negedge clk_i);
        sendByte(cksum);
    endtask

    task automatic pulseRestart();
        restart_i = 1'b1;
        @(negedge clk_i);
        restart_i = 1'b0;
        checkOutput("restart_done", done_o, 0);
        checkOutput("restart_err", err_o, 0);
        checkOutput("restart_words", words_o, 0);
        checkOutput("restart_cpu_rst", cpu_rst_o, 1);
        checkOutput("restart_ready", ready_o, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, ready_o, 1);
        checkOutput({tag, "_we"}, pm_we_o, 0);
        checkOutput({tag, "_addr"}, pm_addr_o, 0);
        checkOutput({tag, "_data"}, pm_data_o, 0);
        checkOutput({tag, "_cpu_rst"}, cpu_rst_o, 1);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
        checkOutput({tag, "_words"}, words_o, 0);
    endtask

    task automatic checkResult(input string tag, input int expDone, input int expWords);
        checkOutput({tag, "_done"}, done_o, expDone);
        checkOutput({tag, "_err"}, err_o, 1 - expDone);
        checkOutput({tag, "_cpu_rst"}, cpu_rst_o, 1 - expDone);
        checkOutput({tag, "_ready"}, ready_o, 0);
        checkOutput({tag, "_words"}, words_o, expWords);
    endtask

    initial begin
        logic [7:0] d[$];

        reset_i   = 1'b1;
        valid_i   = 1'b0;
        byte_i    = 8'h00;
        restart_i = 1'b0;
        #3;
        checkResetValues("reset");
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        checkResetValues("post_reset");

        // Back-to-back frame: 3 bytes, checksum B6.
        d = '{8'hA1, 8'h05, 8'h10};
        applyStimulus(8'h03, d, 8'hB6, 0);
        checkResult("frame3", 1, 3);
        pulseRestart();

        // Full 32-byte frame of FF, checksum wraps to E0.
        d.delete();
        for (int i = 0; i < 32; i++) d.push_back(8'hFF);
        applyStimulus(8'h20, d, 8'hE0, 0);
        checkResult("frame32", 1, 32);
        pulseRestart();

        // Illegal lengths.
        d.delete();
        applyStimulus(8'h00, d, 8'h00, 0);
        repeat (2) @(negedge clk_i);
        checkResult("len00", 0, 0);
        pulseRestart();
        applyStimulus(8'h21, d, 8'h00, 0);
        repeat (2) @(negedge clk_i);
        checkResult("len21", 0, 0);
        pulseRestart();

        // Bad checksum, then recover with a good frame.
        d = '{8'h11, 8'h22};
        applyStimulus(8'h02, d, 8'h34, 0);
        checkResult("badsum", 0, 2);
        pulseRestart();
        d = '{8'h7F};
        applyStimulus(8'h01, d, 8'h7F, 0);
        checkResult("frame1", 1, 1);

        // Restart with a byte offered in the same cycle: the byte must not be taken.
        byte_i  = 8'h00;
        valid_i = 1'b1;
        pulseRestart();
        valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("restart_byte_not_taken_err", err_o, 0);
        checkOutput("restart_byte_not_taken_ready", ready_o, 1);

        // Stalled frame with random gaps on valid_i.
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        applyStimulus(8'h05, d, 8'h0F, 3);
        checkResult("gapped5", 1, 5);
        pulseRestart();

        // Reset in the middle of a 4-byte frame after two data bytes.
        sendByte(8'h04);
        expQ.push_back('{addr: 5'd0, data: 8'hAA});
        sendByte(8'hAA);
        expQ.push_back('{addr: 5'd1, data: 8'hBB});
        sendByte(8'hBB);
        #2 reset_i = 1'b1;
        #1;
        checkResetValues("midreset");
        @(negedge clk_i);
        reset_i = 1'b0;

        // A fresh frame after the abort starts again at address 0.
        d = '{8'h33, 8'h44};
        applyStimulus(8'h02, d, 8'h77, 0);
        checkResult("after_reset", 1, 2);

        repeat (3) @(negedge clk_i);
        checkOutput("pending_writes", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
